norm_arbiter: RTL
=================

# norm_arbiter

Shares one instance of the combinational `normaliser` between two upstream FP result producers, A and B (for example the adder and multiplier back-ends). Each producer presents a pre-normalisation operand set through a valid/ready handshake. The block grants one source per cycle in round-robin order and registers the packed 32-bit result with a source tag behind a valid/ready output stage. It also keeps per-source completion counters.

## Interface
- `CNT_W`, default 16: width of each completion counter.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `a_valid`  in  1  source A operand set valid
- `a_ready`  out  1  source A operand set accepted this cycle
- `a_sig`  in  1  A sign
- `a_exp_max`  in  8  A exponent base
- `a_mant`  in  50  A unsigned pre-normalisation mantissa
- `a_nan`  in  1  A forced-NaN flag
- `a_inf`  in  1  A forced-infinity flag
- `b_valid`, `b_ready`, `b_sig`, `b_exp_max`, `b_mant`, `b_nan`, `b_inf`: same as the A ports, for source B
- `out_valid`  out  1  output register holds a result
- `out_ready`  in  1  consumer accepts the result
- `out_res`  out  32  packed IEEE-754 single-precision result
- `out_src`  out  1  source of `out_res` (0 = A, 1 = B)
- `cnt_a`  out  CNT_W  results from A delivered downstream
- `cnt_b`  out  CNT_W  results from B delivered downstream

## Operation
- State: round-robin pointer `pri`, output register {`out_valid`, `out_res`, `out_src`}, counters `cnt_a` and `cnt_b`.
- Output slot is free when `out_valid == 0` or `out_ready == 1`.
- Grant is combinational:
  - Only one source valid: that source is granted.
  - Both valid: the source named by `pri` is granted (0 = A, 1 = B).
  - Neither valid: no grant.
- `a_ready = grant_A & slot_free`; `b_ready = grant_B & slot_free`. At most one ready is high in any cycle.
- The granted source's fields drive the shared `normaliser` through a mux. When no source is granted, the mux selects A.
- Accept (`x_valid & x_ready`) at an edge loads `out_res` with the normaliser result, sets `out_src` to the source and sets `out_valid` to 1. After the accept, `pri` points to the other source.
- No accept at an edge:
  - If `out_valid & out_ready`, `out_valid` clears.
  - Otherwise the output register holds.
  - `pri` holds.
- Counters:
  - Delivery (`out_valid & out_ready`) increments the counter selected by `out_src`.
  - Counters saturate at all-ones and do not wrap.
- Requester rule: once `x_valid` is raised, it stays high and its fields stay stable until `x_ready`. The block does not check this rule.
- `out_res` and `out_src` stay stable while `out_valid & ~out_ready`.

## Timing
- Reset values (asserted asynchronously): `out_valid = 0`, `out_res = 0`, `out_src = 0`, `pri = 0` (A first), `cnt_a = 0`, `cnt_b = 0`. Both readies are 0 during reset.
- Latency: an operand accepted at edge N appears on `out_res` with `out_valid = 1` after edge N, i.e. in cycle N+1.
- Throughput: one result per cycle while `out_ready` is held high.
- Back-pressure: while `out_valid = 1` and `out_ready = 0`, both readies are 0 and no operand is consumed.
- Simultaneous delivery and accept at one edge: the new result replaces the old one, `out_valid` stays 1, and the delivered source's counter increments.
- Both sources continuously valid with `out_ready = 1`: grants alternate A, B, A, B.
- Reset deasserted mid-transfer: any held result is discarded and not counted. Arbitration restarts with A preferred.

## Test plan
- Reset, then A presents `a_nan = 1` with `out_ready = 1`:
  - `a_ready = 1` in cycle 0.
  - Cycle 1: `out_res = 0x7FFFFFFF`, `out_src = 0`.
  - After edge 1: `cnt_a = 1`.
- A and B both valid continuously, with `a_inf = 1, a_sig = 1` and `b_nan = 1`, and `out_ready = 1`:
  - Outputs alternate `0xFF800000`/src 0 and `0x7FFFFFFF`/src 1, starting with A.
  - After 8 deliveries, `cnt_a = 4` and `cnt_b = 4`.
- Accept one result, then hold `out_ready = 0` for 3 cycles while A and B stay valid:
  - `out_res` is stable and both readies stay 0.
  - Release `out_ready`: the held result is delivered in the same cycle B is accepted.
- Only B valid for 3 consecutive transfers: B is granted every cycle. Then raise A and B together: A is granted first.
- Force `cnt_a` to all-ones (CNT_W = 4, 15 deliveries), then deliver one more A result: `cnt_a` stays 15.
- Assert `rst_n = 0` while `out_valid = 1` and `out_ready = 0`:
  - `out_valid` drops immediately, without waiting for a clock edge.
  - The next grant after reset goes to A.

Source files
------------

// File: rtl/norm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : normaliser, norm_arbiter                                     |
// | Description : Round-robin arbiter that shares one combinational FP         |
// |               normaliser between two producers (A, B) and registers the    |
// |               packed single-precision result with a source tag behind a    |
// |               valid/ready output stage. Keeps saturating per-source        |
// |               delivery counters.                                           |
// |               Normaliser operand format: mant is an unsigned magnitude     |
// |               whose bit 46 has weight 2^(exp_max-127) (so mant = 1<<46     |
// |               with exp_max = 127 is 1.0). Result is truncated; overflow    |
// |               gives infinity, underflow flushes to signed zero.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module normaliser (
   input  logic        sig,
   input  logic [7:0]  exp_max,
   input  logic [49:0] mant,
   input  logic        nan,
   input  logic        inf,
   output logic [31:0] res
);

   localparam logic [10:0] c_point = 11'd46;   // bit position of the unit weight
   localparam logic [10:0] c_emax  = 11'd255;

   logic [5:0]  w_lead;
   logic [5:0]  w_shamt;
   logic [49:0] w_shifted;
   logic [10:0] w_exp_sum;
   logic [22:0] w_frac;

   // Leading-one detection: last hit wins, giving the MSB position.
   always_comb begin
      w_lead = 6'd0;
      for (int i = 0; i < 50; i++) begin
         if (mant[i]) w_lead = 6'(i);
      end
   end

   assign w_shamt   = 6'd49 - w_lead;
   assign w_shifted = mant << w_shamt;
   assign w_frac    = 23'(w_shifted >> 26);
   assign w_exp_sum = {3'b000, exp_max} + {5'b00000, w_lead};

   // Special cases first, then overflow/underflow, then the normal pack.
   always_comb begin
      res = {sig, 31'd0};
      if (nan) begin
         res = 32'h7FFF_FFFF;
      end else if (inf) begin
         res = {sig, 8'hFF, 23'd0};
      end else if (mant == 50'd0) begin
         res = {sig, 31'd0};
      end else if (w_exp_sum >= (c_emax + c_point)) begin
         res = {sig, 8'hFF, 23'd0};
      end else if (w_exp_sum <= c_point) begin
         res = {sig, 31'd0};
      end else begin
         res = {sig, 8'(w_exp_sum - c_point), w_frac};
      end
   end

endmodule

module norm_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic             a_sig,
   input  logic [7:0]       a_exp_max,
   input  logic [49:0]      a_mant,
   input  logic             a_nan,
   input  logic             a_inf,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic             b_sig,
   input  logic [7:0]       b_exp_max,
   input  logic [49:0]      b_mant,
   input  logic             b_nan,
   input  logic             b_inf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic             out_src,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   logic             r_pri;
   logic             r_out_valid;
   logic [31:0]      r_out_res;
   logic             r_out_src;
   logic [CNT_W-1:0] r_cnt_a;
   logic [CNT_W-1:0] r_cnt_b;

   logic        w_slot_free;
   logic        w_grant_a;
   logic        w_grant_b;
   logic        w_acc_a;
   logic        w_acc_b;
   logic        w_deliver;
   logic        w_n_sig;
   logic [7:0]  w_n_exp;
   logic [49:0] w_n_mant;
   logic        w_n_nan;
   logic        w_n_inf;
   logic [31:0] w_n_res;

   // Grant: a lone requester wins; on contention r_pri decides (0 = A).
   assign w_slot_free = ~r_out_valid | out_ready;
   assign w_grant_a   = a_valid & (~b_valid | ~r_pri);
   assign w_grant_b   = b_valid & (~a_valid |  r_pri);
   // rst_n gating keeps both readies low while reset is held.
   assign a_ready     = w_grant_a & w_slot_free & rst_n;
   assign b_ready     = w_grant_b & w_slot_free & rst_n;
   assign w_acc_a     = a_valid & a_ready;
   assign w_acc_b     = b_valid & b_ready;
   assign w_deliver   = r_out_valid & out_ready;

   // Operand mux: B only when B is granted, A otherwise (including idle).
   assign w_n_sig  = w_grant_b ? b_sig     : a_sig;
   assign w_n_exp  = w_grant_b ? b_exp_max : a_exp_max;
   assign w_n_mant = w_grant_b ? b_mant    : a_mant;
   assign w_n_nan  = w_grant_b ? b_nan     : a_nan;
   assign w_n_inf  = w_grant_b ? b_inf     : a_inf;

   normaliser u_norm (
      .sig     (w_n_sig),
      .exp_max (w_n_exp),
      .mant    (w_n_mant),
      .nan     (w_n_nan),
      .inf     (w_n_inf),
      .res     (w_n_res)
   );

   // Output register and round-robin pointer; an accept overrides a delivery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pri       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_res   <= 32'd0;
         r_out_src   <= 1'b0;
      end else if (w_acc_a | w_acc_b) begin
         r_out_valid <= 1'b1;
         r_out_res   <= w_n_res;
         r_out_src   <= w_acc_b;
         r_pri       <= ~w_acc_b;
      end else if (w_deliver) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating delivery counters, selected by the tag of the delivered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_a <= '0;
         r_cnt_b <= '0;
      end else if (w_deliver) begin
         if (!r_out_src && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + 1'b1;
         if ( r_out_src && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_res   = r_out_res;
   assign out_src   = r_out_src;
   assign cnt_a     = r_cnt_a;
   assign cnt_b     = r_cnt_b;

endmodule
`default_nettype wire
